// File: rtl/mem_pkg.sv
// Shared types and default IO addresses for the CPU-side memory/IO responder.
package mem_pkg;

    // Responder sequencing: accept, optional wait states, access, one-cycle response.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } resp_state_t;

    // Which target a latched address selects.
    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_LED  = 2'd1,
        REG_SW   = 2'd2,
        REG_NONE = 2'd3
    } region_t;

    localparam logic [8:0] LED_ADDR_DEF = 9'h100;
    localparam logic [8:0] SW_ADDR_DEF  = 9'h140;

endpackage

// File: rtl/sync_ram.sv
// Single-port word RAM: synchronous write, synchronous read with one-cycle latency.
// Read data only changes on a read, so it holds across idle and write cycles.
module sync_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 16
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage array and registered read port; contents are never cleared.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory/IO responder for the CPU load/store path. Takes one request at a time,
// inserts WAIT_CYCLES wait states, then accesses the word RAM, the LED register
// or the synchronized switch inputs and returns a single-cycle response pulse.
module mem_responder
    import mem_pkg::*;
#(
    parameter int                ADDR_W      = 9,
    parameter int                DATA_W      = 16,
    parameter int                RAM_DEPTH   = 256,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0] LED_ADDR    = LED_ADDR_DEF,
    parameter logic [ADDR_W-1:0] SW_ADDR     = SW_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    input  logic [7:0]        sw_in,
    output logic [7:0]        led_out
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    // Map an address onto a target; only the ADDR_W bits take part, no aliasing.
    function automatic region_t decode_region(input logic [ADDR_W-1:0] addr);
        if (32'(addr) < RAM_DEPTH) return REG_RAM;
        if (addr == LED_ADDR)      return REG_LED;
        if (addr == SW_ADDR)       return REG_SW;
        return REG_NONE;
    endfunction

    resp_state_t       state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    region_t           region;
    logic              ram_en;
    logic [DATA_W-1:0] ram_rdata;
    // Response data comes either straight from the RAM read register or from
    // an IO/zero value captured on the same edge; rd_from_ram picks the source.
    logic              rd_from_ram;
    logic [DATA_W-1:0] rsp_io_q;

    assign region    = decode_region(addr_q);
    assign ram_en    = (state == ACCESS) && (region == REG_RAM);
    assign rsp_rdata = rd_from_ram ? ram_rdata : rsp_io_q;

    sync_ram #(
        .DEPTH  (RAM_DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (we_q),
        .addr  (addr_q[RAM_AW-1:0]),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    // Capture the request fields on the accepting edge; held until the next accept.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    // Request/response sequencer with registered handshake, response and LED outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_io_q    <= '0;
            rd_from_ram <= 1'b0;
            led_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES);
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt == CNT_W'(1)) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    state       <= RESP;
                    rsp_valid   <= 1'b1;
                    rsp_err     <= 1'b0;
                    rsp_io_q    <= '0;
                    rd_from_ram <= 1'b0;
                    case (region)
                        REG_RAM: rd_from_ram <= !we_q;
                        REG_LED: begin
                            if (we_q) begin
                                led_out <= wdata_q[7:0];
                            end else begin
                                rsp_io_q <= DATA_W'(led_out);
                            end
                        end
                        REG_SW: begin
                            if (we_q) begin
                                rsp_err <= 1'b1;
                            end else begin
                                rsp_io_q <= DATA_W'(sw_sync);
                            end
                        end
                        default: rsp_err <= 1'b1;
                    endcase
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with one wait state, one with none.
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [7:0]  sw_in;

    logic        a_req_valid, a_req_we, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [8:0]  a_req_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata;
    logic [7:0]  a_led_out;

    logic        b_req_valid, b_req_we, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [8:0]  b_req_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    logic [7:0]  b_led_out;

    int tests_run;
    int tests_failed;

    mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .sw_in(sw_in), .led_out(a_led_out)
    );

    mem_responder #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .sw_in(sw_in), .led_out(b_led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request on instance a (use_b=0) or b (use_b=1). Call 1 time unit after
    // a rising edge. lat = rising edges from accept to the first sample with
    // rsp_valid high, or -1 if it never arrives.
    task automatic xact(input bit use_b, input logic we, input logic [8:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output logic err, output int lat);
        int guard;
        lat   = -1;
        rdata = 16'hxxxx;
        err   = 1'bx;
        guard = 0;
        while (!(use_b ? b_req_ready : a_req_ready) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (use_b) begin
            b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        end else begin
            a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        end
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (use_b ? b_rsp_valid : a_rsp_valid) begin
                lat   = k;
                rdata = use_b ? b_rsp_rdata : a_rsp_rdata;
                err   = use_b ? b_rsp_err : a_rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests_run++; if (a_req_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        tests_run++; if (a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        tests_run++; if (a_rsp_rdata !== 16'h0000) begin tests_failed++; $display("FAIL reset_rsp_rdata got=%h exp=0000", a_rsp_rdata); end
        tests_run++; if (a_rsp_err !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
        tests_run++; if (a_led_out !== 8'h00) begin tests_failed++; $display("FAIL reset_led_out got=%h exp=00", a_led_out); end
        tests_run++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_b_handshake got=%b%b exp=10", b_req_ready, b_rsp_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL post_reset_idle got=%b%b exp=10", a_req_ready, a_rsp_valid); end
    endtask

    task automatic test_ram_rw();
        logic [15:0] rd; logic er; int lat;
        xact(0, 1'b1, 9'h012, 16'hABCD, rd, er, lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL ram_write_latency got=%0d exp=2", lat); end
        tests_run++; if (er !== 1'b0 || rd !== 16'h0000) begin tests_failed++; $display("FAIL ram_write_rsp got=%b/%h exp=0/0000", er, rd); end
        tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("FAIL ram_resp_ready got=%b exp=0", a_req_ready); end
        xact(0, 1'b0, 9'h012, 16'h0000, rd, er, lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL ram_read_latency got=%0d exp=2", lat); end
        tests_run++; if (rd !== 16'hABCD || er !== 1'b0) begin tests_failed++; $display("FAIL ram_read_data got=%h/%b exp=abcd/0", rd, er); end
        @(posedge clk); #1;
        tests_run++; if (a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rsp_single_cycle got=%b exp=0", a_rsp_valid); end
        tests_run++; if (a_rsp_rdata !== 16'hABCD) begin tests_failed++; $display("FAIL rsp_rdata_hold got=%h exp=abcd", a_rsp_rdata); end
        tests_run++; if (a_req_ready !== 1'b1) begin tests_failed++; $display("FAIL ready_after_resp got=%b exp=1", a_req_ready); end
    endtask

    task automatic test_led();
        logic [15:0] rd; logic er; int lat;
        xact(0, 1'b1, 9'h100, 16'h01FF, rd, er, lat);
        tests_run++; if (a_led_out !== 8'hFF) begin tests_failed++; $display("FAIL led_write got=%h exp=ff", a_led_out); end
        tests_run++; if (er !== 1'b0 || lat !== 2) begin tests_failed++; $display("FAIL led_write_rsp got=%b/%0d exp=0/2", er, lat); end
        xact(0, 1'b0, 9'h100, 16'h0000, rd, er, lat);
        tests_run++; if (rd !== 16'h00FF || er !== 1'b0) begin tests_failed++; $display("FAIL led_read got=%h/%b exp=00ff/0", rd, er); end
    endtask

    task automatic test_switch();
        logic [15:0] rd; logic er; int lat;
        sw_in = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        xact(0, 1'b0, 9'h140, 16'h0000, rd, er, lat);
        tests_run++; if (rd !== 16'h005A || er !== 1'b0) begin tests_failed++; $display("FAIL sw_read got=%h/%b exp=005a/0", rd, er); end
        xact(0, 1'b1, 9'h140, 16'h0033, rd, er, lat);
        tests_run++; if (er !== 1'b1 || rd !== 16'h0000) begin tests_failed++; $display("FAIL sw_write_err got=%b/%h exp=1/0000", er, rd); end
        tests_run++; if (a_led_out !== 8'hFF) begin tests_failed++; $display("FAIL sw_write_led got=%h exp=ff", a_led_out); end
    endtask

    task automatic test_unmapped();
        logic [15:0] rd; logic er; int lat;
        xact(0, 1'b1, 9'h0F0, 16'h5555, rd, er, lat);
        xact(0, 1'b0, 9'h1F0, 16'h0000, rd, er, lat);
        tests_run++; if (lat !== 2 || er !== 1'b1 || rd !== 16'h0000) begin tests_failed++; $display("FAIL unmapped_read got=%0d/%b/%h exp=2/1/0000", lat, er, rd); end
        xact(0, 1'b1, 9'h1F0, 16'hBEEF, rd, er, lat);
        tests_run++; if (er !== 1'b1) begin tests_failed++; $display("FAIL unmapped_write_err got=%b exp=1", er); end
        xact(0, 1'b0, 9'h0F0, 16'h0000, rd, er, lat);
        tests_run++; if (rd !== 16'h5555 || er !== 1'b0) begin tests_failed++; $display("FAIL unmapped_no_alias got=%h/%b exp=5555/0", rd, er); end
        xact(0, 1'b0, 9'h101, 16'h0000, rd, er, lat);
        tests_run++; if (er !== 1'b1 || rd !== 16'h0000) begin tests_failed++; $display("FAIL unmapped_near_led got=%b/%h exp=1/0000", er, rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rd; logic er; int lat;
        xact(1, 1'b1, 9'h031, 16'h2222, rd, er, lat);
        tests_run++; if (lat !== 1 || er !== 1'b0) begin tests_failed++; $display("FAIL w0_latency got=%0d/%b exp=1/0", lat, er); end
        @(posedge clk); #1;
        tests_run++; if (b_req_ready !== 1'b1) begin tests_failed++; $display("FAIL w0_idle_ready got=%b exp=1", b_req_ready); end
        b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 9'h030; b_req_wdata = 16'h0077;
        @(posedge clk); #1;
        tests_run++; if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_access got=%b%b exp=00", b_req_ready, b_rsp_valid); end
        b_req_addr = 9'h031; b_req_wdata = 16'h1111;
        @(posedge clk); #1;
        tests_run++; if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_resp got=%b%b%b exp=010", b_req_ready, b_rsp_valid, b_rsp_err); end
        b_req_we = 1'b0; b_req_addr = 9'h030;
        @(posedge clk); #1;
        tests_run++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle got=%b%b exp=10", b_req_ready, b_rsp_valid); end
        @(posedge clk); #1;
        tests_run++; if (b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_second_accept got=%b%b exp=00", b_req_ready, b_rsp_valid); end
        @(posedge clk); #1;
        tests_run++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 16'h0077) begin tests_failed++; $display("FAIL b2b_read got=%b/%h exp=1/0077", b_rsp_valid, b_rsp_rdata); end
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        xact(1, 1'b0, 9'h031, 16'h0000, rd, er, lat);
        tests_run++; if (rd !== 16'h2222) begin tests_failed++; $display("FAIL b2b_ignored_write got=%h exp=2222", rd); end
    endtask

    task automatic test_reset_abort();
        logic [15:0] rd; logic er; int lat; int seen;
        xact(0, 1'b1, 9'h020, 16'h1234, rd, er, lat);
        tests_run++; if (lat !== 2) begin tests_failed++; $display("FAIL abort_prewrite got=%0d exp=2", lat); end
        @(posedge clk); #1;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 9'h020; a_req_wdata = 16'hFFFF;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        tests_run++; if (a_req_ready !== 1'b0) begin tests_failed++; $display("FAIL abort_in_wait got=%b exp=0", a_req_ready); end
        rst = 1'b1;
        #2;
        tests_run++; if (a_req_ready !== 1'b1 || a_led_out !== 8'h00) begin tests_failed++; $display("FAIL abort_async got=%b/%h exp=1/00", a_req_ready, a_led_out); end
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (a_rsp_valid) seen++;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (a_rsp_valid) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL abort_no_rsp got=%0d exp=0", seen); end
        xact(0, 1'b0, 9'h020, 16'h0000, rd, er, lat);
        tests_run++; if (rd !== 16'h1234 || er !== 1'b0) begin tests_failed++; $display("FAIL abort_no_write got=%h/%b exp=1234/0", rd, er); end
        tests_run++; if (a_led_out !== 8'h00) begin tests_failed++; $display("FAIL abort_led got=%h exp=00", a_led_out); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        sw_in        = 8'h00;
        a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        @(posedge clk); #1;
        test_reset();
        test_ram_rw();
        test_led();
        test_switch();
        test_unmapped();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
